c_frame_rx: RTL and testbench
=============================

C_FRAME_RX -- requirements
Module: c_frame_rx

Interface
REQ-001 Parameter SYNC_WORD, default 8'hA5: frame start pattern, compared MSB-first.
REQ-002 Parameter FRAME_LEN, default 4: data bytes per frame; legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 Port pi_c, input, 1: serial bit stream produced by the upstream top stage (its po_c).
REQ-006 Port pi_c_en, input, 1: sample enable; pi_c is consumed only on cycles where pi_c_en=1.
REQ-007 Port pi_ready, input, 1: downstream accepts the current byte.
REQ-008 Port po_data, output, 8: received data byte, MSB = first received bit.
REQ-009 Port po_last, output, 1: qualifies po_data as the final byte of its frame.
REQ-010 Port po_valid, output, 1: po_data/po_last hold a byte not yet accepted.
REQ-011 Port po_sync, output, 1: one-cycle pulse on sync-word detection.
REQ-012 Port po_ovf, output, 1: sticky overflow flag.

Function
REQ-013 Shift register sr[7:0] SHALL update as sr <= {sr[6:0], pi_c} only on enabled cycles; it holds otherwise.
REQ-014 FSM states SHALL be HUNT and DATA.
REQ-015 In HUNT, on an enabled cycle with {sr[6:0], pi_c} == SYNC_WORD: go to DATA, clear bit_cnt and byte_cnt, and pulse po_sync high for the following cycle.
REQ-016 Sync detection SHALL be sliding-window: every enabled bit is a candidate end of the sync word, with no alignment requirement.
REQ-017 In DATA, each enabled cycle SHALL increment bit_cnt (3 bits, wrapping 7->0).
REQ-018 Byte completion in DATA (the enabled cycle with bit_cnt==7) SHALL produce byte {sr[6:0], pi_c}.
REQ-019 Byte completion SHALL set last = (byte_cnt == FRAME_LEN-1).
REQ-020 Byte completion SHALL increment byte_cnt.
REQ-021 On the completion of the last byte: go to HUNT and clear sr to 8'h00, so a new sync must be fully received and sync bits cannot overlap data bits.
REQ-022 Sync detection SHALL be disabled in DATA; a SYNC_WORD pattern inside the data is treated as data.
REQ-023 Output register load: when a byte completes and (po_valid==0 or pi_ready==1), po_data/po_last SHALL load and po_valid SHALL be 1 on the next cycle.
REQ-024 Latency: po_valid rises one clk after the edge sampling the 8th bit.
REQ-025 Accept: on an edge with po_valid==1, pi_ready==1 and no completing byte, po_valid SHALL clear.
REQ-026 Simultaneous accept and completion SHALL load the new byte with po_valid held at 1, no idle cycle and no overflow.
REQ-027 While po_valid==1 and pi_ready==0, po_data and po_last SHALL remain stable.
REQ-028 A byte completing while po_valid==1 and pi_ready==0 SHALL be dropped and SHALL set po_ovf=1.
REQ-029 After a dropped byte, the FSM and counters SHALL advance as normal, so frame tracking is unaffected.
REQ-030 po_ovf SHALL clear only by rst.
REQ-031 pi_ready while po_valid==0 SHALL have no effect.
REQ-032 pi_c is sampled only when pi_c_en=1; the value on disabled cycles is ignored.

Reset
REQ-033 While rst=1 at a clk edge: state=HUNT, sr=8'h00, bit_cnt=0, byte_cnt=0.
REQ-034 While rst=1 at a clk edge, outputs SHALL be po_data=8'h00, po_last=0, po_valid=0, po_sync=0, po_ovf=0.
REQ-035 rst asserted mid-frame SHALL discard the partial byte and any pending output byte; rst SHALL override all other inputs in that cycle.
REQ-036 The first enabled bit after rst deasserts is eligible as bit 0 of a sync word.

Verification
REQ-037 pi_c_en=1, pi_ready=1, stream A5 11 22 33 44 -> po_sync pulses once; po_valid pulses with 11, 22, 33, 44; po_last=1 only with 44; po_ovf=0.
REQ-038 Stream 3C A5 5A A5 00 00 00 followed by A5 01 02 03 04 -> 5A A5 00 00 is one frame, with the embedded A5 passed as data; the second frame yields 01..04; po_sync pulses exactly twice.
REQ-039 Same frame with pi_c_en toggling 1,0,1,0 and pi_c randomized on disabled cycles -> identical bytes; each po_valid rise is one clk after the 8th enabled sample.
REQ-040 Frame A5 11 22 33 44 with pi_ready=0 throughout -> po_data holds 11 with po_valid=1; po_ovf=1 after byte 22; next frame is still detected.
REQ-041 pi_ready asserted exactly on the edge where byte 22 completes -> 11 accepted, 22 presented the next cycle, po_valid stays 1, po_ovf=0.
REQ-042 rst pulse after A5 and 4 data bits -> all outputs at reset values; subsequent A5 77 ... frame decodes 77 correctly.

Source files
------------

// File: rtl/c_frame_rx.sv
// Serial frame receiver: hunts for a sliding-window sync word, then deserialises
// FRAME_LEN bytes MSB-first into a one-deep valid/ready output register.
module c_frame_rx #(
    parameter logic [7:0] SYNC_WORD = 8'hA5,
    parameter int         FRAME_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pi_c,
    input  logic       pi_c_en,
    input  logic       pi_ready,
    output logic [7:0] po_data,
    output logic       po_last,
    output logic       po_valid,
    output logic       po_sync,
    output logic       po_ovf
);

    typedef enum logic {
        HUNT,
        DATA
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic [7:0] byte_cnt;
    logic [7:0] shifted;
    logic       sync_hit;
    logic       byte_done;
    logic       byte_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        shifted   = {sr[6:0], pi_c};
        state_nxt = state;
        sync_hit  = 1'b0;
        byte_done = 1'b0;
        byte_last = 1'b0;
        case (state)
            HUNT: begin
                if (pi_c_en && (shifted == SYNC_WORD)) begin
                    sync_hit  = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (pi_c_en && (bit_cnt == 3'd7)) begin
                    byte_done = 1'b1;
                    byte_last = (byte_cnt == LAST_IDX);
                    if (byte_last) begin
                        state_nxt = HUNT;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // Clearing sr at frame end keeps data bits from forming part of the next sync word.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= 8'h00;
            bit_cnt  <= 3'd0;
            byte_cnt <= 8'd0;
        end else if (pi_c_en) begin
            sr <= (byte_done && byte_last) ? 8'h00 : shifted;
            if (sync_hit) begin
                bit_cnt  <= 3'd0;
                byte_cnt <= 8'd0;
            end else if (state == DATA) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_done) begin
                    byte_cnt <= byte_cnt + 8'd1;
                end
            end
        end
    end

    // A completing byte is dropped (and flagged) only when the held byte is not being taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            po_data  <= 8'h00;
            po_last  <= 1'b0;
            po_valid <= 1'b0;
            po_sync  <= 1'b0;
            po_ovf   <= 1'b0;
        end else begin
            po_sync <= sync_hit;
            if (byte_done && (!po_valid || pi_ready)) begin
                po_data  <= shifted;
                po_last  <= byte_last;
                po_valid <= 1'b1;
            end else if (byte_done) begin
                po_ovf <= 1'b1;
            end else if (po_valid && pi_ready) begin
                po_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_c_frame_rx.sv
// Self-checking bench for c_frame_rx: directed frame scenarios plus randomized
// streams checked against a bit-list frame decoder model.
module tb_c_frame_rx;

    localparam int         FL   = 4;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       pi_c;
    logic       pi_c_en;
    logic       pi_ready;
    logic [7:0] po_data;
    logic       po_last;
    logic       po_valid;
    logic       po_sync;
    logic       po_ovf;

    int checks = 0;
    int passes = 0;

    bit         stim[$];
    logic [7:0] obs_data[$];
    bit         obs_last[$];
    int         rise_bit[$];
    int         sync_cnt;
    int         bit_idx;

    logic [7:0] exp_data[$];
    bit         exp_last[$];
    int         exp_done[$];
    int         exp_sync;

    c_frame_rx #(.SYNC_WORD(SYNC), .FRAME_LEN(FL)) dut (
        .clk      (clk),
        .rst      (rst),
        .pi_c     (pi_c),
        .pi_c_en  (pi_c_en),
        .pi_ready (pi_ready),
        .po_data  (po_data),
        .po_last  (po_last),
        .po_valid (po_valid),
        .po_sync  (po_sync),
        .po_ovf   (po_ovf)
    );

    always #5 clk = ~clk;

    function automatic bit rand_bit();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) stim.push_back(b[k]);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        pi_c     = 1'b0;
        pi_c_en  = 1'b0;
        pi_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        obs_data.delete();
        obs_last.delete();
        rise_bit.delete();
        stim.delete();
        sync_cnt = 0;
        bit_idx  = 0;
    endtask

    // One clock of stimulus; logs handshakes, valid rises and sync pulses.
    task automatic drive_cycle(input bit c, input bit en, input bit rdy);
        bit pv;
        int consumed;
        pi_c     = c;
        pi_c_en  = en;
        pi_ready = rdy;
        if (po_valid && pi_ready) begin
            obs_data.push_back(po_data);
            obs_last.push_back(po_last);
        end
        pv = po_valid;
        @(posedge clk);
        consumed = bit_idx;
        if (en) bit_idx++;
        #1;
        if (po_valid && !pv) rise_bit.push_back(en ? consumed : -1);
        if (po_sync) sync_cnt++;
    endtask

    // mode 0: always enabled, 1: alternating 1,0, 2: random idle gaps
    task automatic drive_stream(input int mode, input bit rdy);
        foreach (stim[i]) begin
            if (mode == 2) repeat ($urandom_range(2, 0)) drive_cycle(rand_bit(), 1'b0, rdy);
            drive_cycle(stim[i], 1'b1, rdy);
            if (mode == 1) drive_cycle(rand_bit(), 1'b0, rdy);
        end
        repeat (4) drive_cycle(rand_bit(), 1'b0, rdy);
    endtask

    function automatic bit sync_at(input int i, input int start);
        logic [7:0] sw;
        bit         b;
        sw = SYNC;
        for (int k = 0; k < 8; k++) begin
            b = (i - 7 + k < start) ? 1'b0 : stim[i - 7 + k];
            if (b != sw[7 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Decodes the enabled-bit list: find sync, take FL bytes, bits before a new hunt read as zero.
    task automatic run_model();
        int i;
        int start;
        int n;
        logic [7:0] v;
        exp_data.delete();
        exp_last.delete();
        exp_done.delete();
        exp_sync = 0;
        n        = stim.size();
        start    = 0;
        i        = 0;
        while (i < n) begin
            if (sync_at(i, start)) begin
                exp_sync++;
                for (int m = 0; m < FL; m++) begin
                    if (i + 8 * (m + 1) < n) begin
                        v = 8'h00;
                        for (int k = 0; k < 8; k++) v = v * 2 + 8'(stim[i + 8 * m + 1 + k]);
                        exp_data.push_back(v);
                        exp_last.push_back(m == FL - 1);
                        exp_done.push_back(i + 8 * (m + 1));
                    end
                end
                start = i + 8 * FL + 1;
                i     = start;
            end else begin
                i++;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] seq[4];
        seq = '{8'h77, 8'h88, 8'h99, 8'hAA};
        do_reset();
        checks++; if (po_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", po_valid); else passes++;
        checks++; if (po_data !== 8'h00) $display("[TB] FAIL reset_data: got %h want 00", po_data); else passes++;
        checks++; if ({po_last, po_sync, po_ovf} !== 3'b000) $display("[TB] FAIL reset_flags: got %b want 000", {po_last, po_sync, po_ovf}); else passes++;
        push_byte(8'hA5);
        push_byte(8'h11);
        push_byte(8'h22);
        for (int i = 0; i < 20; i++) drive_cycle(stim[i], 1'b1, 1'b0);
        checks++; if ({po_valid, po_data} !== {1'b1, 8'h11}) $display("[TB] FAIL pre_reset_pending: got %b/%h want 1/11", po_valid, po_data); else passes++;
        rst      = 1'b1;
        pi_c_en  = 1'b1;
        pi_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pi_c = rand_bit();
            @(posedge clk);
            #1;
        end
        checks++; if ({po_valid, po_data, po_last, po_sync, po_ovf} !== 12'h0) $display("[TB] FAIL midframe_reset: got v=%b d=%h l=%b s=%b o=%b want all 0", po_valid, po_data, po_last, po_sync, po_ovf); else passes++;
        rst = 1'b0;
        stim.delete();
        obs_data.delete();
        obs_last.delete();
        sync_cnt = 0;
        bit_idx  = 0;
        push_byte(8'hA5);
        foreach (seq[i]) push_byte(seq[i]);
        drive_stream(0, 1'b1);
        checks++; if (obs_data.size() !== 4) $display("[TB] FAIL post_reset_count: got %0d want 4", obs_data.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (obs_data[i] !== seq[i]) $display("[TB] FAIL post_reset_byte%0d: got %h want %h", i, obs_data[i], seq[i]); else passes++;
        end
        checks++; if (sync_cnt !== 1) $display("[TB] FAIL post_reset_sync: got %0d want 1", sync_cnt); else passes++;
    endtask

    task automatic test_basic();
        logic [7:0] want[4];
        want = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        push_byte(8'hA5);
        foreach (want[i]) push_byte(want[i]);
        run_model();
        drive_stream(0, 1'b1);
        checks++; if (obs_data.size() !== 4) $display("[TB] FAIL basic_count: got %0d want 4", obs_data.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({obs_data[i], obs_last[i]} !== {want[i], 1'(i == 3)}) $display("[TB] FAIL basic_byte%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i], want[i], i == 3); else passes++;
            checks++; if (rise_bit[i] !== exp_done[i]) $display("[TB] FAIL basic_latency%0d: valid rose at bit %0d want %0d", i, rise_bit[i], exp_done[i]); else passes++;
        end
        checks++; if (sync_cnt !== 1) $display("[TB] FAIL basic_sync: got %0d want 1", sync_cnt); else passes++;
        checks++; if (po_ovf !== 1'b0) $display("[TB] FAIL basic_ovf: got %b want 0", po_ovf); else passes++;
    endtask

    task automatic test_embedded_sync();
        logic [7:0] in_bytes[12];
        logic [7:0] want[8];
        in_bytes = '{8'h3C, 8'hA5, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04};
        want     = '{8'h5A, 8'hA5, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        do_reset();
        foreach (in_bytes[i]) push_byte(in_bytes[i]);
        drive_stream(0, 1'b1);
        checks++; if (obs_data.size() !== 8) $display("[TB] FAIL embed_count: got %0d want 8", obs_data.size()); else passes++;
        for (int i = 0; i < 8; i++) begin
            checks++; if ({obs_data[i], obs_last[i]} !== {want[i], 1'(i == 3 || i == 7)}) $display("[TB] FAIL embed_byte%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i], want[i], i == 3 || i == 7); else passes++;
        end
        checks++; if (sync_cnt !== 2) $display("[TB] FAIL embed_sync: got %0d want 2", sync_cnt); else passes++;
    endtask

    task automatic test_enable_gaps();
        logic [7:0] want[4];
        want = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        push_byte(8'hA5);
        foreach (want[i]) push_byte(want[i]);
        run_model();
        drive_stream(1, 1'b1);
        checks++; if (obs_data.size() !== 4) $display("[TB] FAIL gaps_count: got %0d want 4", obs_data.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (obs_data[i] !== want[i]) $display("[TB] FAIL gaps_byte%0d: got %h want %h", i, obs_data[i], want[i]); else passes++;
            checks++; if (rise_bit[i] !== exp_done[i]) $display("[TB] FAIL gaps_latency%0d: valid rose at bit %0d want %0d", i, rise_bit[i], exp_done[i]); else passes++;
        end
    endtask

    task automatic test_overflow();
        bit hold_bad;
        hold_bad = 1'b0;
        do_reset();
        push_byte(8'hA5);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        push_byte(8'hA5);
        push_byte(8'h55);
        foreach (stim[i]) begin
            drive_cycle(stim[i], 1'b1, 1'b0);
            if (i == 15) begin
                checks++; if ({po_valid, po_data, po_ovf} !== {1'b1, 8'h11, 1'b0}) $display("[TB] FAIL ovf_first: got v=%b d=%h o=%b want 1/11/0", po_valid, po_data, po_ovf); else passes++;
            end
            if (i == 22) begin
                checks++; if (po_ovf !== 1'b0) $display("[TB] FAIL ovf_early: got %b want 0", po_ovf); else passes++;
            end
            if (i == 23) begin
                checks++; if (po_ovf !== 1'b1) $display("[TB] FAIL ovf_set: got %b want 1", po_ovf); else passes++;
            end
            if (i > 15 && (po_data !== 8'h11 || po_valid !== 1'b1 || po_last !== 1'b0)) hold_bad = 1'b1;
        end
        checks++; if (hold_bad !== 1'b0) $display("[TB] FAIL ovf_hold: got unstable=%b want 0", hold_bad); else passes++;
        checks++; if (sync_cnt !== 2) $display("[TB] FAIL ovf_next_sync: got %0d want 2", sync_cnt); else passes++;
        checks++; if (po_ovf !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b want 1", po_ovf); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] want[4];
        want = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        push_byte(8'hA5);
        foreach (want[i]) push_byte(want[i]);
        foreach (stim[i]) begin
            drive_cycle(stim[i], 1'b1, 1'(i >= 23));
            if (i == 22) begin
                checks++; if ({po_valid, po_data} !== {1'b1, 8'h11}) $display("[TB] FAIL b2b_held: got %b/%h want 1/11", po_valid, po_data); else passes++;
            end
            if (i == 23) begin
                checks++; if ({po_valid, po_data, po_ovf} !== {1'b1, 8'h22, 1'b0}) $display("[TB] FAIL b2b_swap: got v=%b d=%h o=%b want 1/22/0", po_valid, po_data, po_ovf); else passes++;
            end
        end
        repeat (4) drive_cycle(rand_bit(), 1'b0, 1'b1);
        checks++; if (obs_data.size() !== 4) $display("[TB] FAIL b2b_count: got %0d want 4", obs_data.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({obs_data[i], obs_last[i]} !== {want[i], 1'(i == 3)}) $display("[TB] FAIL b2b_byte%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i], want[i], i == 3); else passes++;
        end
        checks++; if (po_ovf !== 1'b0) $display("[TB] FAIL b2b_ovf: got %b want 0", po_ovf); else passes++;
    endtask

    task automatic test_random();
        int nframes;
        for (int t = 0; t < 8; t++) begin
            do_reset();
            repeat ($urandom_range(20, 0)) stim.push_back(rand_bit());
            nframes = $urandom_range(2, 1);
            for (int f = 0; f < nframes; f++) begin
                push_byte(SYNC);
                repeat (FL) push_byte(8'($urandom_range(255, 0)));
                repeat ($urandom_range(6, 0)) stim.push_back(rand_bit());
            end
            run_model();
            drive_stream((t % 2 == 0) ? 2 : 0, 1'b1);
            checks++; if (obs_data.size() !== exp_data.size()) $display("[TB] FAIL rand%0d_count: got %0d want %0d", t, obs_data.size(), exp_data.size()); else passes++;
            foreach (exp_data[i]) begin
                checks++; if ({obs_data[i], obs_last[i]} !== {exp_data[i], exp_last[i]}) $display("[TB] FAIL rand%0d_byte%0d: got %h/%b want %h/%b", t, i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]); else passes++;
                checks++; if (rise_bit[i] !== exp_done[i]) $display("[TB] FAIL rand%0d_latency%0d: valid rose at bit %0d want %0d", t, i, rise_bit[i], exp_done[i]); else passes++;
            end
            checks++; if (sync_cnt !== exp_sync) $display("[TB] FAIL rand%0d_sync: got %0d want %0d", t, sync_cnt, exp_sync); else passes++;
            checks++; if (po_ovf !== 1'b0) $display("[TB] FAIL rand%0d_ovf: got %b want 0", t, po_ovf); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_embedded_sync();
        test_enable_gaps();
        test_overflow();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
